red_pitaya_bus_initiator: RTL and testbench

RED_PITAYA_BUS_INITIATOR -- requirements
Module: red_pitaya_bus_initiator

---
 rtl/red_pitaya_bus_initiator.sv | 177 +++++++++++++++++
 tb/tb_red_pitaya_bus_initiator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_bus_initiator.sv
// Command-FIFO-fed bus initiator: queues read/write commands, issues each one as
// a one-cycle strobe on the system bus, waits for ack/err (or times out), and
// returns a one-cycle response pulse.
module red_pitaya_bus_initiator #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        sys_clk_i,
    input  logic        sys_rstn_i,
    // command side
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    // response side
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    // bus request
    output logic [31:0] sys_addr_o,
    output logic [31:0] sys_wdata_o,
    output logic [3:0]  sys_sel_o,
    output logic        sys_wen_o,
    output logic        sys_ren_o,
    // bus reply
    input  logic [31:0] sys_rdata_i,
    input  logic        sys_err_i,
    input  logic        sys_ack_i,
    // status
    output logic        busy_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [15:0] TIMEOUT = 16'(ACK_TIMEOUT);

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    cmd_t          mem_q [FIFO_DEPTH];
    cmd_t          mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic          ready_en_q, ready_en_d;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [15:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d, rsp_timeout_q, rsp_timeout_d;

    logic fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (fifo_cnt_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt_q == '0);
    // Ready is held low until the first clock after reset release.
    assign cmd_ready_o = ready_en_q && !fifo_full;
    assign push = cmd_valid_i && cmd_ready_o;
    // The head is consumed when the FSM can start a new transaction.
    assign pop  = !fifo_empty && (state_q == S_IDLE || state_q == S_RESP);

    // FIFO storage, pointers and occupancy count
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ready_en_d = 1'b1;
        if (push) begin
            mem_d[wr_ptr_q] = '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end

    // Transaction FSM: next state, bus registers, wait counter and response capture
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wait_cnt_d    = wait_cnt_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (pop) begin
                    we_d    = mem_q[rd_ptr_q].we;
                    addr_d  = mem_q[rd_ptr_q].addr;
                    wdata_d = mem_q[rd_ptr_q].wdata;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 16'd1;
                // err takes priority over a simultaneous ack
                if (sys_err_i) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RESP;
                end else if (sys_ack_i) begin
                    rsp_rdata_d   = we_q ? 32'd0 : sys_rdata_i;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RESP;
                end else if (wait_cnt_d == TIMEOUT) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            ready_en_q    <= 1'b0;
            state_q       <= S_IDLE;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wait_cnt_q    <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            ready_en_q    <= ready_en_d;
            state_q       <= state_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign sys_addr_o    = addr_q;
    assign sys_wdata_o   = wdata_q;
    assign sys_sel_o     = (state_q == S_ISSUE) ? 4'hF : 4'h0;
    assign sys_wen_o     = (state_q == S_ISSUE) &&  we_q;
    assign sys_ren_o     = (state_q == S_ISSUE) && !we_q;
    assign rsp_valid_o   = (state_q == S_RESP);
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign busy_o        = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_red_pitaya_bus_initiator.sv
// Directed bench for red_pitaya_bus_initiator: inputs change and outputs are
// observed on the falling clock edge.
module tb_red_pitaya_bus_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        cmd_ready;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] sys_addr, sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen, sys_ren;
    logic [31:0] sys_rdata = '0;
    logic        sys_err = 1'b0, sys_ack = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    red_pitaya_bus_initiator #(.FIFO_DEPTH(4), .ACK_TIMEOUT(8)) dut (
        .sys_clk_i(clk), .sys_rstn_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .rsp_timeout_o(rsp_timeout),
        .sys_addr_o(sys_addr), .sys_wdata_o(sys_wdata), .sys_sel_o(sys_sel),
        .sys_wen_o(sys_wen), .sys_ren_o(sys_ren),
        .sys_rdata_i(sys_rdata), .sys_err_i(sys_err), .sys_ack_i(sys_ack),
        .busy_o(busy)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(); step();
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
        checks++; if ({sys_wen, sys_ren, sys_sel, rsp_valid} !== 7'd0) begin errors++; $display("FAIL rst_strobes: got %b exp 0", {sys_wen, sys_ren, sys_sel, rsp_valid}); end
        checks++; if (sys_addr !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h exp 0", sys_addr); end
        rst_n = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_early: got %b exp 0", cmd_ready); end
        step();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b exp 1", cmd_ready); end
    endtask

    task automatic test_write();
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h4000_0001; cmd_wdata = 32'h1;
        step();
        cmd_valid = 1'b0;
        checks++; if (sys_wen !== 1'b0) begin errors++; $display("FAIL wr_early_wen: got %b exp 0", sys_wen); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b exp 1", busy); end
        step();
        checks++; if ({sys_wen, sys_ren} !== 2'b10) begin errors++; $display("FAIL wr_strobe: got %b exp 10", {sys_wen, sys_ren}); end
        checks++; if (sys_sel !== 4'hF) begin errors++; $display("FAIL wr_sel: got %h exp f", sys_sel); end
        checks++; if (sys_addr !== 32'h4000_0001 || sys_wdata !== 32'h1) begin errors++; $display("FAIL wr_addr_data: got %h/%h exp 40000001/00000001", sys_addr, sys_wdata); end
        step();
        checks++; if ({sys_wen, sys_ren, sys_sel} !== 6'd0) begin errors++; $display("FAIL wr_strobe_wait: got %b exp 0", {sys_wen, sys_ren, sys_sel}); end
        checks++; if (sys_addr !== 32'h4000_0001 || sys_wdata !== 32'h1) begin errors++; $display("FAIL wr_hold: got %h/%h exp 40000001/00000001", sys_addr, sys_wdata); end
        sys_ack = 1'b1;
        step();
        sys_ack = 1'b0;
        checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin errors++; $display("FAIL wr_rsp: got %b exp 100", {rsp_valid, rsp_err, rsp_timeout}); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL wr_rdata: got %h exp 0", rsp_rdata); end
        step();
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL wr_end: got %b exp 00", {rsp_valid, busy}); end
    endtask

    task automatic test_read();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h4000_0001; cmd_wdata = 32'h0;
        step();
        cmd_valid = 1'b0;
        step();
        checks++; if ({sys_wen, sys_ren} !== 2'b01) begin errors++; $display("FAIL rd_strobe: got %b exp 01", {sys_wen, sys_ren}); end
        sys_ack = 1'b1; sys_rdata = 32'hDEAD_BEEF;   // ack during ISSUE must be ignored
        step();
        sys_ack = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_issue_ack: got %b exp 0", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_wait: got %b exp 0", rsp_valid); end
        step();
        sys_ack = 1'b1; sys_rdata = 32'h0000_0001;
        step();
        sys_ack = 1'b0; sys_rdata = 32'h0000_0055;
        checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin errors++; $display("FAIL rd_rsp: got %b exp 100", {rsp_valid, rsp_err, rsp_timeout}); end
        checks++; if (rsp_rdata !== 32'h1) begin errors++; $display("FAIL rd_rdata: got %h exp 00000001", rsp_rdata); end
        step();
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h1) begin errors++; $display("FAIL rd_hold: got %b/%h exp 0/00000001", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_timeout();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h4000_0200;
        step();
        cmd_valid = 1'b0;
        step();
        checks++; if (sys_ren !== 1'b1) begin errors++; $display("FAIL to_strobe: got %b exp 1", sys_ren); end
        for (int k = 0; k < 8; k++) begin
            step();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL to_early_%0d: got %b exp 0", k, rsp_valid); end
        end
        step();
        checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b111) begin errors++; $display("FAIL to_rsp: got %b exp 111", {rsp_valid, rsp_err, rsp_timeout}); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL to_rdata: got %h exp 0", rsp_rdata); end
        sys_ack = 1'b1; sys_rdata = 32'hFFFF_FFFF;   // stray late ack
        step();
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL to_stray1: got %b exp 00", {rsp_valid, busy}); end
        step();
        sys_ack = 1'b0;
        checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b011) begin errors++; $display("FAIL to_stray2: got %b exp 011", {rsp_valid, rsp_err, rsp_timeout}); end
    endtask

    task automatic test_ack_err();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h4000_0300;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        sys_ack = 1'b1; sys_err = 1'b1; sys_rdata = 32'h1234_5678;
        step();
        sys_ack = 1'b0; sys_err = 1'b0;
        checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin errors++; $display("FAIL ae_rsp: got %b exp 110", {rsp_valid, rsp_err, rsp_timeout}); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL ae_rdata: got %h exp 0", rsp_rdata); end
        step();
    endtask

    task automatic test_fifo_full();
        int   issued = 0;
        int   resp = 0;
        logic pending = 1'b0;
        logic exp_we;
        for (int i = 0; i < 6; i++) begin
            if (sys_wen || sys_ren) begin
                checks++; if (sys_addr !== 32'h4000_0100 + 32'(4 * issued)) begin errors++; $display("FAIL ff_order_push: got %h exp %h", sys_addr, 32'h4000_0100 + 32'(4 * issued)); end
                issued++; pending = 1'b1;
            end
            checks++; if (cmd_ready !== (i < 5)) begin errors++; $display("FAIL ff_ready_%0d: got %b exp %b", i, cmd_ready, (i < 5)); end
            cmd_valid = 1'b1; cmd_we = (i == 2);
            cmd_addr = 32'h4000_0100 + 32'(4 * i); cmd_wdata = 32'hC0DE_0000 + 32'(i);
            step();
        end
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ff_full: got %b exp 0", cmd_ready); end
        for (int cyc = 0; cyc < 100 && resp < 5; cyc++) begin
            sys_ack = 1'b0;
            if (rsp_valid) begin
                checks++; if (rsp_rdata !== ((resp == 2) ? 32'd0 : 32'h1000_0000 + 32'(resp))) begin errors++; $display("FAIL ff_rdata_%0d: got %h", resp, rsp_rdata); end
                resp++;
            end
            if (sys_wen || sys_ren) begin
                exp_we = (issued == 2);
                checks++; if (sys_addr !== 32'h4000_0100 + 32'(4 * issued)) begin errors++; $display("FAIL ff_order: got %h exp %h", sys_addr, 32'h4000_0100 + 32'(4 * issued)); end
                checks++; if ({sys_wen, sys_ren} !== {exp_we, !exp_we}) begin errors++; $display("FAIL ff_dir_%0d: got %b", issued, {sys_wen, sys_ren}); end
                if (exp_we) begin
                    checks++; if (sys_wdata !== 32'hC0DE_0002) begin errors++; $display("FAIL ff_wdata: got %h exp c0de0002", sys_wdata); end
                end
                issued++; pending = 1'b1;
            end else if (pending) begin
                sys_ack = 1'b1; sys_rdata = 32'h1000_0000 + 32'(issued - 1); pending = 1'b0;
            end
            step();
        end
        sys_ack = 1'b0;
        checks++; if (resp !== 5 || issued !== 5) begin errors++; $display("FAIL ff_count: got %0d/%0d exp 5/5", issued, resp); end
        step(); step();
        checks++; if ({busy, sys_wen, sys_ren} !== 3'b000) begin errors++; $display("FAIL ff_drop6: got %b exp 000", {busy, sys_wen, sys_ren}); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h4000_0400 + 32'(4 * i);
            step();
        end
        cmd_valid = 1'b0;
        checks++; if (busy !== 1'b1 || sys_addr !== 32'h4000_0400) begin errors++; $display("FAIL rm_pre: got %b/%h exp 1/40000400", busy, sys_addr); end
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, cmd_ready, rsp_valid, sys_ren, sys_wen, sys_sel} !== 9'd0) begin errors++; $display("FAIL rm_outs: got %b exp 0", {busy, cmd_ready, rsp_valid, sys_ren, sys_wen, sys_sel}); end
        checks++; if (sys_addr !== 32'd0 || rsp_rdata !== 32'd0) begin errors++; $display("FAIL rm_data: got %h/%h exp 0/0", sys_addr, rsp_rdata); end
        sys_ack = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();
        sys_ack = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid || sys_ren || sys_wen || busy) bad++;
            step();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rm_after: got %0d active cycles exp 0", bad); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b exp 1", cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_err();
        test_fifo_full();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
